// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: tracks EX/MEM/WB destinations and drives the
// load-use interlock, per-source forwarding selects and a saturating stall counter.
module hazard_scoreboard #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ds_valid,
  input  logic [4:0]       ds_rs_addr,
  input  logic [4:0]       ds_rt_addr,
  input  logic             ds_rs_used,
  input  logic             ds_rt_used,
  input  logic             issue,
  input  logic             issue_we,
  input  logic [4:0]       issue_waddr,
  input  logic             issue_load,
  input  logic             es_fire,
  input  logic             ms_fire,
  input  logic             ws_fire,
  input  logic             ms_rdata_valid,
  input  logic             flush,
  output logic             ds_stall,
  output logic [1:0]       rs_fwd_sel,
  output logic [1:0]       rt_fwd_sel,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic       v;
    logic       we;
    logic [4:0] waddr;
    logic       load;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '0;

  slot_t            es_q, es_d, ms_q, ms_d, ws_q, ws_d;
  logic             ld_done_q, ld_done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       rs_res_s, rt_res_s;

  // Returns {stall, sel[1:0]}; youngest matching producer wins.
  function automatic logic [2:0] resolve(input logic used, input logic [4:0] addr,
                                         input slot_t es, input slot_t ms,
                                         input slot_t ws, input logic ld_done);
    logic [2:0] r;
    r = 3'b000;
    if (!used || addr == 5'd0) begin
      r = 3'b000;
    end else if (es.v && es.we && es.waddr == addr) begin
      r = es.load ? 3'b100 : 3'b001;
    end else if (ms.v && ms.we && ms.waddr == addr) begin
      r = (ms.load && !ld_done) ? 3'b100 : 3'b010;
    end else if (ws.v && ws.we && ws.waddr == addr) begin
      r = 3'b011;
    end else begin
      r = 3'b000;
    end
    return r;
  endfunction

  // Slot advance: every slot is computed from the pre-edge contents.
  always_comb begin
    ws_d = ws_q;
    if (ms_fire) ws_d = ms_q;
    else if (ws_fire) ws_d = SLOT_EMPTY;
    else ws_d = ws_q;

    ms_d = ms_q;
    if (es_fire) ms_d = es_q;
    else if (ms_fire) ms_d = SLOT_EMPTY;
    else ms_d = ms_q;

    es_d = es_q;
    if (issue && !flush) es_d = '{v: 1'b1, we: issue_we, waddr: issue_waddr, load: issue_load};
    else if (es_fire || flush) es_d = SLOT_EMPTY;
    else es_d = es_q;

    ld_done_d = ld_done_q;
    if (es_fire || ms_fire) ld_done_d = 1'b0;
    else if (ms_q.v && ms_q.load && ms_rdata_valid) ld_done_d = 1'b1;
    else ld_done_d = ld_done_q;
  end

  // Interlock and forwarding selects, combinational from slot state and decode fields.
  always_comb begin
    rs_res_s = resolve(ds_rs_used, ds_rs_addr, es_q, ms_q, ws_q, ld_done_q);
    rt_res_s = resolve(ds_rt_used, ds_rt_addr, es_q, ms_q, ws_q, ld_done_q);
    if (ds_valid) begin
      ds_stall   = rs_res_s[2] | rt_res_s[2];
      rs_fwd_sel = rs_res_s[1:0];
      rt_fwd_sel = rt_res_s[1:0];
    end else begin
      ds_stall   = 1'b0;
      rs_fwd_sel = 2'd0;
      rt_fwd_sel = 2'd0;
    end
  end

  // Stall counter saturates at all-ones.
  always_comb begin
    if (ds_stall && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1'b1);
    else cnt_d = cnt_q;
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      es_q      <= SLOT_EMPTY;
      ms_q      <= SLOT_EMPTY;
      ws_q      <= SLOT_EMPTY;
      ld_done_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      es_q      <= es_d;
      ms_q      <= ms_d;
      ws_q      <= ws_d;
      ld_done_q <= ld_done_d;
      cnt_q     <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Tracks destination registers of instructions in flight in the EX, MEM and WB stages of the 5-stage MIPS pipeline.
- Drives the decode-stage interlock (`ds_stall`, gated into `ds_ready_go`) and per-source forwarding selects for the rs/rt operand muxes.
- Keeps a saturating stall-cycle performance counter.
- Sits beside the decode stage and is fed by the inter-stage handshake fire signals.

Parameters:
- `CNT_W`, 32, width of the stall-cycle counter.

Ports:
- `clk`  in  1  core clock.
- `reset`  in  1  asynchronous active-low reset: 0 = reset asserted.
- `ds_valid`  in  1  decode stage holds a valid instruction.
- `ds_rs_addr`  in  5  decode rs index.
- `ds_rt_addr`  in  5  decode rt index.
- `ds_rs_used`  in  1  instruction reads rs.
- `ds_rt_used`  in  1  instruction reads rt.
- `issue`  in  1  decode→EX transfer this cycle (`ds_to_es_valid && es_allowin`).
- `issue_we`  in  1  issued instruction writes the RF.
- `issue_waddr`  in  5  issued destination register.
- `issue_load`  in  1  issued instruction is a load.
- `es_fire`  in  1  EX→MEM transfer this cycle.
- `ms_fire`  in  1  MEM→WB transfer this cycle.
- `ws_fire`  in  1  WB retires this cycle.
- `ms_rdata_valid`  in  1  load data returned for the MEM-stage instruction.
- `flush`  in  1  kill the EX-stage instruction and any same-cycle issue.
- `ds_stall`  out  1  decode must not issue.
- `rs_fwd_sel`  out  2  rs source: 0 = RF, 1 = EX, 2 = MEM, 3 = WB.
- `rt_fwd_sel`  out  2  rt source, same encoding.
- `stall_cnt`  out  `CNT_W`  saturating count of stalled decode cycles.

Behaviour:
- Three slots: ES, MS, WS.
  - Each slot holds {v, we, waddr[4:0], load}.
  - The MS slot also holds `ld_done`.
- Reset (reset = 0, async):
  - All slot v, we, load and `ld_done` = 0.
  - `stall_cnt` = 0.
  - Outputs `ds_stall` = 0, `fwd_sel` = 0.
- Slot update, every posedge, all slots computed from pre-edge values:
  - WS ← MS if `ms_fire`; else invalid if `ws_fire`; else hold.
  - MS ← ES if `es_fire`; else invalid if `ms_fire`; else hold.
  - ES ← {1, `issue_we`, `issue_waddr`, `issue_load`} if `issue && !flush`; else invalid if (`es_fire` or `flush`); else hold.
  - Simultaneous `es_fire && issue`: MS takes the old ES and ES takes the new instruction.
  - `flush && es_fire` in the same cycle: the old ES still moves to MS, and no new ES entry is created.
- `ld_done`:
  - Cleared when MS is reloaded or invalidated.
  - Set when MS.v && MS.load && `ms_rdata_valid`.
  - Sticky until the slot changes.
- Match, per source s (rs or rt):
  - A source hazards only if s_used && addr != 0.
  - Slot X matches if X.v && X.we && X.waddr == addr.
  - Priority is ES > MS > WS (youngest producer wins).
- Per-source result (combinational, no latency):
  - ES match, ES.load = 1 → stall.
  - ES match, non-load → sel 1.
  - MS match, MS.load && !`ld_done` → stall.
  - MS match, otherwise → sel 2.
  - WS match → sel 3.
  - No match → sel 0.
- `ds_stall` = `ds_valid` && (rs stall || rt stall).
- `fwd_sel` outputs are valid whenever `ds_valid` = 1; 0 when `ds_valid` = 0.
- rs and rt are evaluated independently. The same register on both sources gives identical sels.
- `ds_stall` does not depend on `issue` or `flush` (no combinational loop). The decode stage must gate `ds_ready_go` with `!ds_stall`.
- `issue` while `ds_stall` = 1 is illegal. Bench assertion only; the RTL ignores it.
- `stall_cnt`:
  - +1 each cycle `ds_stall` = 1.
  - Holds at 2^`CNT_W` − 1 (no wrap).
- Register $0 writes are tracked but never match.
- Reset mid-operation clears all slots immediately. The first cycle after release has no hazards.

Test Plan:
- Back-to-back ALU dependency:
  - Stimulus: issue addu $3, all fires = 1; next cycle decode with rs = 3.
  - Required: `rs_fwd_sel` = 1, `ds_stall` = 0.
  - After one more advance the sel is 2, after another it is 3, then 0.
- Load-use:
  - Stimulus: issue lw $5; decode with rt = 5 next cycle.
  - Required: `ds_stall` = 1 while the load is in ES.
  - After `es_fire`, with `ms_rdata_valid` = 0: stall persists.
  - When `ms_rdata_valid` = 1: stall drops the following cycle and `rt_fwd_sel` = 2.
  - `stall_cnt` equals the number of stalled cycles (e.g. 3).
- Priority:
  - Stimulus: WS writes $7 (ALU), MS writes $7 (ALU), ES writes $7 (ALU); decode rs = 7.
  - Required: `rs_fwd_sel` = 1.
  - Then make ES a load with the same setup. Required: `ds_stall` = 1.
- $0 and unused source:
  - Stimulus: ES writes $0 and decode rs = 0; separately, ES is a load to $9 with decode rt = 9 but `rt_used` = 0.
  - Required: no stall, sel 0 in both cases.
- Flush:
  - Stimulus: ES holds load $4, `flush` = 1 with `issue` = 1; next cycle decode rs = 4.
  - Required: ES is empty, no stall, sel 0.
  - Then assert reset low mid-stream. Required: slots clear, `stall_cnt` = 0.
- Counter saturation:
  - Stimulus: `CNT_W` = 4, hold a load-use stall for 20 cycles.
  - Required: `stall_cnt` stops at 15.
